// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encodings and the parity helper,
// which the matching transmitter also uses.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_BRK_WAIT = 3'd5
    } rx_state_t;

    // Parity bit a transmitter would send for 'data' (zero-extended to 9 bits).
    function automatic logic f_parity(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with show-ahead read; full/empty resolved with an extra pointer bit.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             i_Clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_Clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver: synchroniser, framing FSM and shift register,
// with error-tagged words buffered in a valid/ready FIFO.
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 50,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 i_Clock,
    input  logic                 reset,
    input  logic                 i_Rx_Serial,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err,
    output logic                 o_Rx_Valid,
    input  logic                 i_Rx_Ready,
    output logic                 o_Overrun,
    input  logic                 i_Err_Clr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    rx_state_t            state;
    logic                 rx_meta;
    logic                 rx_sync;
    logic [CW-1:0]        count;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] data_sr;
    logic                 parity_bit;
    logic                 frame_acc;

    logic                 push;
    logic                 parity_err_now;
    logic [DATA_BITS+1:0] push_word;
    logic [DATA_BITS+1:0] head_word;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop_eff;

    assign push = (state == S_STOP) && (count == CNT_MAX) && (stop_idx == STOP_LAST);
    assign parity_err_now = (PARITY_EN != 0) &&
                            (f_parity(9'(data_sr), PARITY_ODD != 0) != parity_bit);
    // The last stop sample is folded in combinationally since the word is pushed in that cycle.
    assign push_word = {parity_err_now, frame_acc | ~rx_sync, data_sr};
    assign pop_eff   = ~fifo_empty & i_Rx_Ready;

    always_ff @(posedge i_Clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (reset) begin
            state      <= S_IDLE;
            count      <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            data_sr    <= '0;
            parity_bit <= 1'b0;
            frame_acc  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    count <= '0;
                    if (!rx_sync) state <= S_START;
                end
                S_START: begin
                    if (count == CNT_HALF) begin
                        count   <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_DATA: begin
                    if (count == CNT_MAX) begin
                        count   <= '0;
                        data_sr <= {rx_sync, data_sr[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST) begin
                            stop_idx  <= 1'b0;
                            frame_acc <= 1'b0;
                            state     <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (count == CNT_MAX) begin
                        count      <= '0;
                        parity_bit <= rx_sync;
                        state      <= S_STOP;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_STOP: begin
                    if (count == CNT_MAX) begin
                        count <= '0;
                        if (stop_idx == STOP_LAST) begin
                            state <= rx_sync ? S_IDLE : S_BRK_WAIT;
                        end else begin
                            stop_idx  <= 1'b1;
                            frame_acc <= frame_acc | ~rx_sync;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_BRK_WAIT: begin
                    if (rx_sync) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if (reset) begin
            o_Overrun <= 1'b0;
        end else if (push && fifo_full && !pop_eff) begin
            o_Overrun <= 1'b1;
        end else if (i_Err_Clr) begin
            o_Overrun <= 1'b0;
        end
    end

    uart_sync_fifo #(
        .WIDTH(DATA_BITS + 2),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_Clock(i_Clock),
        .reset  (reset),
        .push   (push),
        .wr_data(push_word),
        .pop    (pop_eff),
        .rd_data(head_word),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign o_Rx_Data    = head_word[DATA_BITS-1:0];
    assign o_Frame_Err  = head_word[DATA_BITS];
    assign o_Parity_Err = head_word[DATA_BITS+1];
    assign o_Rx_Valid   = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: four instances cover 8N1, 8E1, 8O1 and 8N2 framing.
module tb_uart_rx_framed;
    import uart_pkg::*;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rx, rdy, clr;
    logic [3:0] vld, ferr, perr, ovr;
    logic [7:0] dat [4];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int rise_cyc  = 0;
    logic arm = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (arm && vld[0]) begin rise_cyc = cyc; arm = 1'b0; end

    uart_rx_framed #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) u_n1 (
        .i_Clock(clk), .reset(reset), .i_Rx_Serial(rx[0]), .o_Rx_Data(dat[0]),
        .o_Frame_Err(ferr[0]), .o_Parity_Err(perr[0]), .o_Rx_Valid(vld[0]),
        .i_Rx_Ready(rdy[0]), .o_Overrun(ovr[0]), .i_Err_Clr(clr[0]));

    uart_rx_framed #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) u_e1 (
        .i_Clock(clk), .reset(reset), .i_Rx_Serial(rx[1]), .o_Rx_Data(dat[1]),
        .o_Frame_Err(ferr[1]), .o_Parity_Err(perr[1]), .o_Rx_Valid(vld[1]),
        .i_Rx_Ready(rdy[1]), .o_Overrun(ovr[1]), .i_Err_Clr(clr[1]));

    uart_rx_framed #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) u_o1 (
        .i_Clock(clk), .reset(reset), .i_Rx_Serial(rx[2]), .o_Rx_Data(dat[2]),
        .o_Frame_Err(ferr[2]), .o_Parity_Err(perr[2]), .o_Rx_Valid(vld[2]),
        .i_Rx_Ready(rdy[2]), .o_Overrun(ovr[2]), .i_Err_Clr(clr[2]));

    uart_rx_framed #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                     .STOP_BITS(2), .FIFO_DEPTH(4)) u_n2 (
        .i_Clock(clk), .reset(reset), .i_Rx_Serial(rx[3]), .o_Rx_Data(dat[3]),
        .o_Frame_Err(ferr[3]), .o_Parity_Err(perr[3]), .o_Rx_Valid(vld[3]),
        .i_Rx_Ready(rdy[3]), .o_Overrun(ovr[3]), .i_Err_Clr(clr[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold_bit(input int unsigned u, input logic b);
        rx[u] = b;
        repeat (C) @(negedge clk);
    endtask

    task automatic send_frame(input int unsigned u, input logic [7:0] d, input logic par_en,
                              input logic par_bit, input int unsigned nstop, input logic last_low);
        @(negedge clk);
        start_cyc = cyc;
        hold_bit(u, 1'b0);
        for (int i = 0; i < 8; i++) hold_bit(u, d[i]);
        if (par_en) hold_bit(u, par_bit);
        for (int unsigned s = 0; s < nstop; s++) hold_bit(u, !(last_low && s == nstop - 1));
    endtask

    task automatic pop(input int unsigned u);
        @(negedge clk);
        rdy[u] = 1'b1;
        @(negedge clk);
        rdy[u] = 1'b0;
    endtask

    initial begin
        rx = '1; rdy = '0; clr = '0; reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(vld[0]), 32'd0);
        chk("rst_overrun", 32'(ovr[0]), 32'd0);
        chk("rst_data", 32'(dat[0]), 32'd0);
        chk("rst_errs", 32'({ferr[0], perr[0]}), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // 1: 8N1 0xA5 and line-to-valid latency 3 + 7 + 9*16
        arm = 1'b1;
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b0);
        chk("t1_valid", 32'(vld[0]), 32'd1);
        chk("t1_data", 32'(dat[0]), 32'hA5);
        chk("t1_errs", 32'({ferr[0], perr[0]}), 32'd0);
        chk("t1_latency", 32'(rise_cyc - start_cyc - 1), 32'd154);
        pop(0);
        chk("t1_pop_valid", 32'(vld[0]), 32'd0);

        // 2: start glitch of 5 cycles
        @(negedge clk);
        rx[0] = 1'b0;
        repeat (5) @(negedge clk);
        rx[0] = 1'b1;
        repeat (2 * C) @(negedge clk);
        chk("t2_state", 32'(u_n1.state), 32'(S_IDLE));
        chk("t2_valid", 32'(vld[0]), 32'd0);

        // 3: parity even (error expected) then odd (clean)
        send_frame(1, 8'h03, 1'b1, 1'b1, 1, 1'b0);
        chk("t3e_data", 32'(dat[1]), 32'h03);
        chk("t3e_perr", 32'(perr[1]), 32'd1);
        chk("t3e_ferr", 32'(ferr[1]), 32'd0);
        send_frame(2, 8'h03, 1'b1, 1'b1, 1, 1'b0);
        chk("t3o_valid", 32'(vld[2]), 32'd1);
        chk("t3o_data", 32'(dat[2]), 32'h03);
        chk("t3o_errs", 32'({ferr[2], perr[2]}), 32'd0);

        // 4: 8N2 second stop low, then break held 30 bit times
        send_frame(3, 8'h81, 1'b0, 1'b0, 2, 1'b1);
        repeat (30 * C) @(negedge clk);
        chk("t4_brk_state", 32'(u_n2.state), 32'(S_BRK_WAIT));
        chk("t4_valid", 32'(vld[3]), 32'd1);
        chk("t4_data", 32'(dat[3]), 32'h81);
        chk("t4_ferr", 32'(ferr[3]), 32'd1);
        pop(3);
        chk("t4_one_word", 32'(vld[3]), 32'd0);
        rx[3] = 1'b1;
        repeat (2 * C) @(negedge clk);
        send_frame(3, 8'h5A, 1'b0, 1'b0, 2, 1'b0);
        chk("t4_clean_data", 32'(dat[3]), 32'h5A);
        chk("t4_clean_errs", 32'({ferr[3], perr[3]}), 32'd0);
        pop(3);

        // 5: overrun with depth 4
        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i * 8'h11), 1'b0, 1'b0, 1, 1'b0);
        chk("t5_overrun", 32'(ovr[0]), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("t5_pop%0d", i), 32'(dat[0]), 32'(i * 8'h11));
            pop(0);
        end
        chk("t5_empty", 32'(vld[0]), 32'd0);
        chk("t5_sticky", 32'(ovr[0]), 32'd1);
        @(negedge clk); clr[0] = 1'b1;
        @(negedge clk); clr[0] = 1'b0;
        chk("t5_clr", 32'(ovr[0]), 32'd0);

        // 6: reset in the middle of 0x3C data bits
        @(negedge clk);
        hold_bit(0, 1'b0);
        hold_bit(0, 1'b0);
        hold_bit(0, 1'b0);
        hold_bit(0, 1'b1);
        reset = 1'b1; rx[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_rst_state", 32'(u_n1.state), 32'(S_IDLE));
        reset = 1'b0;
        repeat (C) @(negedge clk);
        chk("t6_idle_valid", 32'(vld[0]), 32'd0);
        send_frame(0, 8'hC3, 1'b0, 1'b0, 1, 1'b0);
        chk("t6_data", 32'(dat[0]), 32'hC3);
        chk("t6_overrun", 32'(ovr[0]), 32'd0);
        pop(0);
        chk("t6_only_one", 32'(vld[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
